// File: rtl/config_trits_decoder_if.sv
// CSR bus bundle for config_trits_decoder.
//   csr_a   5  register address
//   csr_di  8  write data
//   csr_we  1  write strobe, one cycle per write
//   csr_do  8  read data, combinational from csr_a
// master = bus owner (CPU side), slave = the decoder.
interface config_trits_decoder_if;
   logic [4:0] csr_a;
   logic [7:0] csr_di;
   logic       csr_we;
   logic [7:0] csr_do;

   modport master (output csr_a, output csr_di, output csr_we, input csr_do);
   modport slave  (input csr_a, input csr_di, input csr_we, output csr_do);
endinterface

// File: rtl/config_trits_decoder.sv
// config_trits_decoder: classifies four tri-level strap pins as strapped
// low, strapped high or floating. Each scan drives the pins high, releases
// and samples them, then drives low, releases and samples again. A floating
// pin keeps the last driven level on its parasitic capacitance; a strapped
// pin returns to its strap level.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   csr           CSR bus (slave modport): BASE_ADDR = ctrl/status,
//                 BASE_ADDR+1 = result
//   trits  [3:0]  strap pins (bidirectional)
//   busy          scan in progress
//   valid         trit_code holds a completed scan result
//   trit_code[7:0] 2 bits per pin, pin n at [2n+1:2n]
//                 00 low, 01 high, 10 floating, 11 contended
module config_trits_decoder #(
   parameter logic [4:0] BASE_ADDR  = 5'h0,
   parameter int         SETTLE     = 4,
   parameter int         FLOAT_WAIT = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   config_trits_decoder_if.slave        csr,
   inout  wire  [3:0]                   trits,
   output logic                         busy,
   output logic                         valid,
   output logic [7:0]                   trit_code
);

   localparam int MAXC = (SETTLE > FLOAT_WAIT) ? SETTLE : FLOAT_WAIT;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] SET_LD = CW'(SETTLE - 1);
   localparam logic [CW-1:0] FLT_LD = CW'(FLOAT_WAIT - 1);
   localparam logic [4:0]    RES_ADDR = BASE_ADDR + 5'd1;

   typedef enum logic [2:0] {
      IDLE, DRIVE_HI, FLOAT_HI, DRIVE_LO, FLOAT_LO, DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          oe;
   logic          outval;
   logic          auto_pend;   // set by reset: start one scan on the first edge after release
   logic [3:0]    sync1, sync2;
   logic [3:0]    s_hi, s_lo;
   logic [7:0]    code_nxt;
   logic          sw_start;

   // One shared driver for all four pins; reset releases them asynchronously via oe.
   assign trits = oe ? {4{outval}} : 4'bz;

   assign busy     = (state != IDLE);
   assign sw_start = csr.csr_we && (csr.csr_a == BASE_ADDR) && csr.csr_di[0];

   // Only csr_di[0] carries meaning; the rest of the write data is don't-care.
   wire unused_di = &{1'b0, csr.csr_di[7:1]};

   // Decode: {hi,lo} 00->00, 11->01, 10->10 (held driven level), 01->11.
   for (genvar i = 0; i < 4; i++) begin : g_dec
      assign code_nxt[2*i+1:2*i] = {s_hi[i] ^ s_lo[i], s_lo[i]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         oe        <= 1'b0;
         outval    <= 1'b0;
         auto_pend <= 1'b1;
         sync1     <= 4'h0;
         sync2     <= 4'h0;
         s_hi      <= 4'h0;
         s_lo      <= 4'h0;
         valid     <= 1'b0;
         trit_code <= 8'h00;
      end else begin
         sync1 <= trits;
         sync2 <= sync1;
         case (state)
            IDLE: begin
               if (auto_pend || sw_start) begin
                  state     <= DRIVE_HI;
                  cnt       <= SET_LD;
                  oe        <= 1'b1;
                  outval    <= 1'b1;
                  auto_pend <= 1'b0;
                  if (sw_start) valid <= 1'b0;
               end
            end
            DRIVE_HI: begin
               if (cnt == '0) begin
                  state <= FLOAT_HI;
                  cnt   <= FLT_LD;
                  oe    <= 1'b0;
               end else cnt <= cnt - 1'b1;
            end
            FLOAT_HI: begin
               if (cnt == '0) begin
                  s_hi   <= sync2;
                  state  <= DRIVE_LO;
                  cnt    <= SET_LD;
                  oe     <= 1'b1;
                  outval <= 1'b0;
               end else cnt <= cnt - 1'b1;
            end
            DRIVE_LO: begin
               if (cnt == '0) begin
                  state <= FLOAT_LO;
                  cnt   <= FLT_LD;
                  oe    <= 1'b0;
               end else cnt <= cnt - 1'b1;
            end
            FLOAT_LO: begin
               if (cnt == '0) begin
                  s_lo  <= sync2;
                  state <= DONE;
                  cnt   <= '0;
               end else cnt <= cnt - 1'b1;
            end
            DONE: begin
               trit_code <= code_nxt;
               valid     <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      csr.csr_do = 8'h00;
      if (csr.csr_a == BASE_ADDR)     csr.csr_do = {busy, valid, 6'b0};
      else if (csr.csr_a == RES_ADDR) csr.csr_do = trit_code;
   end

endmodule

// File: tb/tb_config_trits_decoder.sv
module tb_config_trits_decoder;
   localparam int S = 4;
   localparam int F = 16;
   localparam int LAST = 2*S + 2*F;           // DONE position; scan spans 0..LAST
   localparam logic [4:0] BASE = 5'h0;
   localparam logic [4:0] RES  = 5'h1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   config_trits_decoder_if bus();
   wire  [3:0] pad;
   logic       tb_drv;
   logic [3:0] tb_val;
   assign pad = tb_drv ? tb_val : 4'bz;

   logic       busy, valid;
   logic [7:0] trit_code;

   config_trits_decoder #(.BASE_ADDR(BASE), .SETTLE(S), .FLOAT_WAIT(F)) dut (
      .clk(clk), .rst(rst), .csr(bus), .trits(pad),
      .busy(busy), .valid(valid), .trit_code(trit_code));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: scan position (-1 = idle), results, per-pin board model.
   // Pin modes: 0 strap low, 1 strap high, 2 keeper (floating), 3 contended.
   int         m_pos = -1;
   bit         m_auto = 1'b1;
   bit         m_valid = 1'b0;
   logic [7:0] m_code = 8'h00;
   logic [3:0] m_hi = 4'h0, m_lo = 4'h0;
   int         mode[4];
   logic       keep_lvl = 1'b0;
   bit         rand_modes = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_drive();
      return m_pos >= 0 && (m_pos < S || (m_pos >= S+F && m_pos < 2*S+F));
   endfunction

   function automatic logic m_lvl();
      return (m_pos >= 0 && m_pos < S);
   endfunction

   // Level a pin settles to when the DUT is not driving it.
   function automatic logic pin_level(input int md, input int pos);
      case (md)
         0: return 1'b0;
         1: return 1'b1;
         2: return keep_lvl;
         default: return (pos >= 2*S+F && pos < 2*S+2*F);  // 0 in high-float, 1 in low-float
      endcase
   endfunction

   function automatic logic [1:0] classify(input logic hi, input logic lo);
      case ({hi, lo})
         2'b00: return 2'b00;
         2'b11: return 2'b01;
         2'b10: return 2'b10;
         default: return 2'b11;
      endcase
   endfunction

   task automatic model_reset();
      m_pos = -1; m_auto = 1'b1; m_valid = 1'b0; m_code = 8'h00; m_hi = 4'h0; m_lo = 4'h0;
   endtask

   task automatic model_edge();
      bit sw;
      sw = bus.csr_we && bus.csr_a == BASE && bus.csr_di[0];
      if (rst) model_reset();
      else if (m_pos < 0) begin
         if (m_auto || sw) begin
            m_pos = 0; m_auto = 1'b0;
            if (sw) m_valid = 1'b0;
            if (rand_modes) for (int i = 0; i < 4; i++) mode[i] = int'($urandom_range(0, 3));
         end
      end else if (m_pos == LAST) begin
         for (int i = 0; i < 4; i++) m_code[2*i +: 2] = classify(m_hi[i], m_lo[i]);
         m_valid = 1'b1; m_pos = -1;
      end else begin
         if (m_pos == S+F-1) for (int i = 0; i < 4; i++) m_hi[i] = pin_level(mode[i], m_pos);
         if (m_pos == LAST-1) for (int i = 0; i < 4; i++) m_lo[i] = pin_level(mode[i], m_pos);
         m_pos++;
      end
   endtask

   task automatic update_pad();
      if (m_drive()) begin
         tb_drv = 1'b0;
         keep_lvl = m_lvl();
      end else begin
         tb_drv = 1'b1;
         for (int i = 0; i < 4; i++) tb_val[i] = pin_level(mode[i], m_pos);
      end
   endtask

   task automatic check_all();
      logic [7:0] exp_do;
      exp_do = 8'h00;
      if (bus.csr_a == BASE) exp_do = {(m_pos >= 0), m_valid, 6'b0};
      else if (bus.csr_a == RES) exp_do = m_code;
      chk("busy", 32'(busy), 32'(m_pos >= 0));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("trit_code", 32'(trit_code), 32'(m_code));
      chk("csr_do", 32'(bus.csr_do), 32'(exp_do));
      if (m_drive()) chk("pad_drive", 32'(pad), 32'({4{m_lvl()}}));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1 update_pad();
      @(negedge clk);
      check_all();
      bus.csr_we = 1'b0;
      bus.csr_di = 8'h00;
      bus.csr_a  = 5'($urandom_range(0, 3));
   endtask

   task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
      bus.csr_we = 1'b1; bus.csr_a = a; bus.csr_di = d;
      step();
   endtask

   // Runs until busy falls (bounded); returns number of busy cycles seen.
   task automatic run_scan(output int nb);
      nb = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (busy) nb++;
         else if (nb > 0) break;
      end
      chk("scan_ended", 32'(busy), 32'd0);
   endtask

   task automatic reset_pulse(input int hold);
      rst = 1'b1;
      #1;
      model_reset();
      update_pad();
      check_all();
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_code", 32'(trit_code), 32'h00);
      for (int k = 0; k < hold; k++) step();
      rst = 1'b0;
   endtask

   initial begin
      int nb;
      rst = 1'b1;
      bus.csr_we = 1'b0; bus.csr_a = BASE; bus.csr_di = 8'h00;
      tb_val = 4'h0;
      for (int i = 0; i < 4; i++) mode[i] = 0;
      model_reset();
      update_pad();
      step(); step();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_code", 32'(trit_code), 32'h00);

      // Straps: pins 0/1 low, 2/3 high; auto-start on release.
      mode[0] = 0; mode[1] = 0; mode[2] = 1; mode[3] = 1;
      update_pad();
      rst = 1'b0;
      run_scan(nb);
      chk("auto_scan_len", 32'(nb), 32'd41);
      chk("strap_code", 32'(trit_code), 32'h50);
      bus.csr_a = RES; #1;
      chk("rd_result", 32'(bus.csr_do), 32'h50);
      bus.csr_a = BASE; #1;
      chk("rd_status", 32'(bus.csr_do), 32'h40);

      // Floating pin 1 (keeper), others low; software restart.
      mode[0] = 0; mode[1] = 2; mode[2] = 0; mode[3] = 0;
      @(negedge clk);
      update_pad();
      csr_write(BASE, 8'h01);
      chk("restart_valid", 32'(valid), 32'd0);
      chk("restart_busy", 32'(busy), 32'd1);
      run_scan(nb);
      chk("sw_scan_len", 32'(nb + 1), 32'd41);
      chk("float_code", 32'(trit_code), 32'h08);

      // Contended pin 3; second start mid-scan and result write are ignored.
      mode[1] = 0; mode[3] = 3;
      update_pad();
      csr_write(BASE, 8'hFF);
      nb = 1;
      for (int k = 0; k < 10; k++) begin step(); if (busy) nb++; end
      csr_write(BASE, 8'h01); if (busy) nb++;
      csr_write(RES, 8'hFF);  if (busy) nb++;
      begin
         int rest;
         run_scan(rest);
         nb += rest;
      end
      chk("restart_ignored_len", 32'(nb), 32'd41);
      chk("contend_code", 32'(trit_code), 32'hC0);
      csr_write(RES, 8'h12);
      chk("res_write_ignored", 32'(trit_code), 32'hC0);

      // Reset during DRIVE_LO.
      csr_write(BASE, 8'h01);
      for (int k = 0; k < 100 && m_pos != S+F+1; k++) step();
      chk("reached_drive_lo", 32'(m_pos), 32'(S+F+1));
      reset_pulse(2);
      run_scan(nb);
      chk("post_reset_len", 32'(nb), 32'd41);
      chk("post_reset_code", 32'(trit_code), 32'hC0);

      // Randomized traffic, pin modes and resets.
      rand_modes = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 399) == 0) reset_pulse(int'($urandom_range(1, 3)));
         else if ($urandom_range(0, 19) == 0) begin
            bus.csr_we = 1'b1;
            bus.csr_a  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1));
            bus.csr_di = 8'($urandom);
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
